// File: rtl/led_scan_pkg.sv
// Shared types and width helpers for the HUB75 row-scan driver.
// Widths derive from the geometry parameters of the instantiating module.
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_e;

  localparam int LAT_TICKS = 2;

  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int col_w(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

  function automatic int pix_aw(input int rows, input int cols);
    return 1 + row_w(rows) + col_w(cols);
  endfunction

endpackage

// File: rtl/led_scan_ctrl_tick.sv
// Tick generator: one-clk tick every DIV clks plus a half-period phase.
// Both restart from zero while clear is high.
module led_tick_gen
  import led_scan_pkg::*;
#(
  parameter int DIV = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick,
  output logic phase
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    tick    = (cnt_q == CW'(DIV - 1));
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (tick) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/led_scan_ctrl.sv
// HUB75 row-scan driver: shifts row r+1 while row r is lit,
// OE-window brightness and frame-synchronous bank swap.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int COLS     = 64,
  parameter int ROWS     = 16,
  parameter int DIV      = 3,
  parameter int BRIGHT_W = 8,
  parameter bit INVERT   = 1'b1,
  localparam int ROW_W   = row_w(ROWS),
  localparam int COL_W   = col_w(COLS),
  localparam int PIX_AW  = pix_aw(ROWS, COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic                frame_start,
  output logic [PIX_AW-1:0]   pix_addr,
  input  logic                pix_rdata,
  output logic [ROW_W-1:0]    led_addr,
  output logic                led_oe_n,
  output logic                led_di,
  output logic                led_clk,
  output logic                led_lat
);

  localparam int LAT_W = (LAT_TICKS > 1) ? $clog2(LAT_TICKS) : 1;
  localparam logic [COL_W-1:0]    BIT_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [BRIGHT_W-1:0] WIN_LAST = '1;
  localparam logic [LAT_W-1:0]    LAT_LAST = LAT_W'(LAT_TICKS - 1);

  state_e              state_q, state_d;
  logic                bank_q, bank_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    bit_q, bit_d;
  logic                shift_done_q, shift_done_d;
  logic                win_on_q, win_on_d;
  logic [BRIGHT_W-1:0] disp_q, disp_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                issue_q, issue_d;
  logic                rd_vld_q, rd_vld_d;
  logic [PIX_AW-1:0]   pix_addr_q, pix_addr_d;
  logic [ROW_W-1:0]    led_addr_q, led_addr_d;
  logic                led_oe_n_q, led_oe_n_d;
  logic                led_di_q, led_di_d;
  logic                led_clk_q, led_clk_d;
  logic                led_lat_q, led_lat_d;
  logic                swap_ack_q, swap_ack_d;
  logic                frame_start_q, frame_start_d;

  logic tick, phase, restart, tick_clr;
  logic sh_fin, wn_fin;

  assign tick_clr = (state_q == IDLE) || restart;

  led_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clr),
    .tick  (tick),
    .phase (phase)
  );

  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    row_d         = row_q;
    bit_d         = bit_q;
    shift_done_d  = shift_done_q;
    win_on_d      = win_on_q;
    disp_d        = disp_q;
    bright_d      = bright_q;
    lat_cnt_d     = lat_cnt_q;
    issue_d       = 1'b0;
    rd_vld_d      = issue_q;
    pix_addr_d    = pix_addr_q;
    led_addr_d    = led_addr_q;
    led_oe_n_d    = led_oe_n_q;
    led_di_d      = led_di_q;
    led_clk_d     = led_clk_q;
    led_lat_d     = led_lat_q;
    swap_ack_d    = 1'b0;
    frame_start_d = 1'b0;
    restart       = 1'b0;
    sh_fin = shift_done_q || (phase && (bit_q == BIT_LAST));
    wn_fin = !win_on_q || (disp_q == WIN_LAST);

    // RAM data arrives one clk after the address was presented
    if (rd_vld_q) led_di_d = pix_rdata ^ INVERT;

    unique case (state_q)
      IDLE: begin
        led_oe_n_d = 1'b1;
        led_clk_d  = 1'b0;
        led_lat_d  = 1'b0;
        if (enable) begin
          state_d      = SHIFT;
          win_on_d     = 1'b0;
          disp_d       = '0;
          bit_d        = '0;
          shift_done_d = 1'b0;
          issue_d      = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!shift_done_q) begin
            if (!phase) begin
              led_clk_d = 1'b1;
            end else begin
              led_clk_d = 1'b0;
              if (bit_q == BIT_LAST) begin
                shift_done_d = 1'b1;
              end else begin
                bit_d   = bit_q + 1'b1;
                issue_d = 1'b1;
              end
            end
          end
          if (win_on_q) begin
            if (disp_q == WIN_LAST) win_on_d = 1'b0;
            disp_d = disp_q + 1'b1;
          end
          led_oe_n_d = !(win_on_d && (disp_d < bright_q));
          if (sh_fin && wn_fin) begin
            state_d       = LATCH;
            lat_cnt_d     = '0;
            led_lat_d     = 1'b1;
            led_oe_n_d    = 1'b1;
            led_clk_d     = 1'b0;
            led_addr_d    = row_q;
            bright_d      = brightness;
            frame_start_d = (row_q == '0);
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            if ((row_q == ROW_LAST) && swap_req) begin
              bank_d     = ~bank_q;
              swap_ack_d = 1'b1;
            end
          end
        end
      end
      LATCH: begin
        led_oe_n_d = 1'b1;
        if (tick) begin
          led_lat_d = 1'b0;
          if (lat_cnt_q == LAT_LAST) begin
            restart = 1'b1;
            if (enable) begin
              state_d      = SHIFT;
              win_on_d     = 1'b1;
              disp_d       = '0;
              led_oe_n_d   = (bright_q == '0);
              bit_d        = '0;
              shift_done_d = 1'b0;
              issue_d      = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Columns go out MSB-first: bit 0 of a row reads column COLS-1
    if (issue_d) pix_addr_d = {bank_q, row_q, BIT_LAST - bit_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bank_q        <= 1'b0;
      row_q         <= '0;
      bit_q         <= '0;
      shift_done_q  <= 1'b0;
      win_on_q      <= 1'b0;
      disp_q        <= '0;
      bright_q      <= '0;
      lat_cnt_q     <= '0;
      issue_q       <= 1'b0;
      rd_vld_q      <= 1'b0;
      pix_addr_q    <= '0;
      led_addr_q    <= '0;
      led_oe_n_q    <= 1'b1;
      led_di_q      <= 1'b0;
      led_clk_q     <= 1'b0;
      led_lat_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      row_q         <= row_d;
      bit_q         <= bit_d;
      shift_done_q  <= shift_done_d;
      win_on_q      <= win_on_d;
      disp_q        <= disp_d;
      bright_q      <= bright_d;
      lat_cnt_q     <= lat_cnt_d;
      issue_q       <= issue_d;
      rd_vld_q      <= rd_vld_d;
      pix_addr_q    <= pix_addr_d;
      led_addr_q    <= led_addr_d;
      led_oe_n_q    <= led_oe_n_d;
      led_di_q      <= led_di_d;
      led_clk_q     <= led_clk_d;
      led_lat_q     <= led_lat_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign pix_addr    = pix_addr_q;
  assign led_addr    = led_addr_q;
  assign led_oe_n    = led_oe_n_q;
  assign led_di      = led_di_q;
  assign led_clk     = led_clk_q;
  assign led_lat     = led_lat_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl: 8x4 panel, DIV=2, 4-bit brightness.
// Per-row and per-bit records are gathered at negedge and checked against tables.
module tb_led_scan_ctrl;

  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int DIV  = 2;
  localparam int BW   = 4;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [BW-1:0] brightness;
  logic          swap_req;
  logic          swap_ack;
  logic          frame_start;
  logic [AW-1:0] pix_addr;
  logic          pix_rdata = 1'b0;
  logic [1:0]    led_addr;
  logic          led_oe_n;
  logic          led_di;
  logic          led_clk;
  logic          led_lat;

  always #5 clk = ~clk;

  led_scan_ctrl #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .DIV      (DIV),
    .BRIGHT_W (BW),
    .INVERT   (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .brightness  (brightness),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .pix_addr    (pix_addr),
    .pix_rdata   (pix_rdata),
    .led_addr    (led_addr),
    .led_oe_n    (led_oe_n),
    .led_di      (led_di),
    .led_clk     (led_clk),
    .led_lat     (led_lat)
  );

  logic mem [0:63];
  always @(posedge clk) pix_rdata <= mem[pix_addr];

  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [AW-1:0] rise_addr[$];
  logic          rise_di[$];
  int            rise_cyc[$];
  int            lat_addr[$];
  int            lat_cyc[$];
  int            lat_rises[$];
  int            lat_oe[$];
  int            ack_cyc[$];
  int            fs_cyc[$];
  int            row_rises = 0;
  int            oe_low = 0;
  int            oe_in_lat = 0;
  logic          prev_clk = 1'b0;
  logic          prev_lat = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_clk  = 1'b0;
      prev_lat  = 1'b0;
      row_rises = 0;
      oe_low    = 0;
    end else begin
      if (led_clk && !prev_clk) begin
        rise_addr.push_back(pix_addr);
        rise_di.push_back(led_di);
        rise_cyc.push_back(cyc);
        row_rises++;
      end
      if (!led_oe_n) begin
        oe_low++;
        if (led_lat) oe_in_lat++;
      end
      if (led_lat && !prev_lat) begin
        lat_addr.push_back(int'(led_addr));
        lat_cyc.push_back(cyc);
        lat_rises.push_back(row_rises);
        lat_oe.push_back(oe_low);
        row_rises = 0;
        oe_low    = 0;
      end
      if (swap_ack)    ack_cyc.push_back(cyc);
      if (frame_start) fs_cyc.push_back(cyc);
      prev_clk = led_clk;
      prev_lat = led_lat;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " led_addr"}, 32'(led_addr), 0);
    check({tag, " led_oe_n"}, 32'(led_oe_n), 1);
    check({tag, " led_di"}, 32'(led_di), 0);
    check({tag, " led_clk"}, 32'(led_clk), 0);
    check({tag, " led_lat"}, 32'(led_lat), 0);
    check({tag, " swap_ack"}, 32'(swap_ack), 0);
    check({tag, " frame_start"}, 32'(frame_start), 0);
    check({tag, " pix_addr"}, 32'(pix_addr), 0);
  endtask

  typedef struct {
    int addr;
    int rises;
    int oe;
    int cyc;
  } lat_vec_t;

  typedef struct {
    int addr;
    int di;
  } bit_vec_t;

  lat_vec_t lat_tab[7];
  bit_vec_t bit_tab[8];

  initial begin
    logic [7:0] b0;
    logic [7:0] b1;
    int         n0;
    int         n;
    int         bad;
    int         late;

    lat_tab[0] = '{0, 8, 0, 33};
    lat_tab[1] = '{1, 8, 10, 69};
    lat_tab[2] = '{2, 8, 10, 105};
    lat_tab[3] = '{3, 8, 10, 141};
    lat_tab[4] = '{0, 8, 10, 177};
    lat_tab[5] = '{1, 8, 0, 213};
    lat_tab[6] = '{2, 8, 30, 249};

    bit_tab[0] = '{7, 0};
    bit_tab[1] = '{6, 1};
    bit_tab[2] = '{5, 0};
    bit_tab[3] = '{4, 1};
    bit_tab[4] = '{3, 1};
    bit_tab[5] = '{2, 1};
    bit_tab[6] = '{1, 0};
    bit_tab[7] = '{0, 0};

    b0 = 8'b1010_0011;
    b1 = 8'b0110_1001;
    for (int a = 0; a < 64; a++) mem[a] = ((a * 7 + 3) % 5) < 2;
    for (int c = 0; c < 8; c++) begin
      mem[c]      = b0[c];
      mem[32 + c] = b1[c];
    end

    rst_n      = 1'b0;
    enable     = 1'b1;
    swap_req   = 1'b0;
    brightness = 4'd5;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (cyc >= 360) break;
      swap_req   = (cyc >= 50) && (ack_cyc.size() == 0);
      brightness = (cyc < 150) ? 4'd5 : (cyc < 190) ? 4'd0 : 4'd15;
      enable     = (cyc < 230);
    end

    check("lat_count", lat_cyc.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < lat_cyc.size()) begin
        check($sformatf("row%0d led_addr", i), lat_addr[i], lat_tab[i].addr);
        check($sformatf("row%0d rises", i), lat_rises[i], lat_tab[i].rises);
        check($sformatf("row%0d oe_low_clks", i), lat_oe[i], lat_tab[i].oe);
        check($sformatf("row%0d lat_cyc", i), lat_cyc[i], lat_tab[i].cyc);
      end
    end

    check("rise_count", rise_addr.size(), 56);
    check("first_rise_cyc", (rise_cyc.size() > 0) ? rise_cyc[0] : -1, 3);
    for (int k = 0; k < 8; k++) begin
      if (k < rise_addr.size()) begin
        check($sformatf("bit%0d pix_addr", k), 32'(rise_addr[k]), bit_tab[k].addr);
        check($sformatf("bit%0d led_di", k), 32'(rise_di[k]), bit_tab[k].di);
      end
    end

    check("swap_ack_count", ack_cyc.size(), 1);
    check("swap_ack_cyc", (ack_cyc.size() > 0) ? ack_cyc[0] : -1, 141);
    check("frame_start_count", fs_cyc.size(), 2);
    check("frame_start_cyc0", (fs_cyc.size() > 0) ? fs_cyc[0] : -1, 33);
    check("frame_start_cyc1", (fs_cyc.size() > 1) ? fs_cyc[1] : -1, 177);
    if (rise_addr.size() > 40) begin
      check("pre_swap_bank", 32'(rise_addr[31][5]), 0);
      check("post_swap_addr", 32'(rise_addr[32]), 32'h27);
      for (int k = 0; k < 8; k++)
        check($sformatf("bank1 bit%0d led_di", k), 32'(rise_di[32 + k]),
              32'(!b1[7 - k]));
    end

    bad = 0;
    for (int i = 0; i < rise_addr.size(); i++)
      if (rise_di[i] !== !mem[rise_addr[i]]) bad++;
    check("led_di_vs_mem", bad, 0);
    check("oe_low_in_latch", oe_in_lat, 0);

    late = 0;
    for (int i = 0; i < rise_cyc.size(); i++)
      if (rise_cyc[i] > 249) late++;
    check("idle_no_led_clk", late, 0);
    check("idle_oe_low_clks", oe_low, 0);
    check("idle_led_oe_n", 32'(led_oe_n), 1);
    check("idle_led_clk", 32'(led_clk), 0);

    enable = 1'b1;
    n = 0;
    while (!led_lat && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("relatch_seen", 32'(led_lat), 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_reset("reset_mid_latch");

    n0 = rise_addr.size();
    rst_n = 1'b1;
    n = 0;
    while (rise_addr.size() <= n0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("restart_rise_seen", rise_addr.size() > n0, 1);
    if (rise_addr.size() > n0) begin
      check("restart_pix_addr", 32'(rise_addr[n0]), 32'h07);
      check("restart_rise_cyc", rise_cyc[n0], 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
